usehint_ctrl: RTL and testbench
===============================

USEHINT_CTRL -- requirements
Module: usehint_ctrl

Interface
REQ-001 SHALL have parameter R_WIDTH, default 32, meaning the width of each r coefficient.
REQ-002 SHALL have parameter R1_WIDTH, default 4, meaning the width of each r1 output coefficient.
REQ-003 SHALL have parameter NPOLY, default package k, meaning the number of polynomials per job.
REQ-004 SHALL have port clk, in, 1, the single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port reset, in, 1, reset that is asynchronous and active-low (asserted at 0).
REQ-006 SHALL have port start, in, 1, a one-cycle job request sampled only in IDLE.
REQ-007 SHALL have port busy, out, 1, high from the cycle after an accepted start until done.
REQ-008 SHALL have port done, out, 1, a one-cycle pulse after the last write is accepted.
REQ-009 SHALL have port rd_en, out, 1, the read strobe to the r/h coefficient memory.
REQ-010 SHALL have port rd_addr, out, $clog2(NPOLY)+8, the read address {poly, coeff}.
REQ-011 SHALL have port rd_r, in, R_WIDTH, the r coefficient, valid 1 cycle after rd_en; memory holds rd_r and rd_h when rd_en=0.
REQ-012 SHALL have port rd_h, in, 1, the hint bit, with the same timing as rd_r.
REQ-013 SHALL have port wr_valid, out, 1, marking an r1 result as valid.
REQ-014 SHALL have port wr_ready, in, 1, the sink handshake; a transfer occurs when wr_valid && wr_ready.
REQ-015 SHALL have port wr_addr, out, $clog2(NPOLY)+8, the result address {poly, coeff}.
REQ-016 SHALL have port wr_data, out, R1_WIDTH, the UseHint result r1.

Function
REQ-017 SHALL implement FSM IDLE->RUN on start; RUN->DRAIN after read NPOLY*256-1 is issued; DRAIN->DONE when the final write transfers; DONE->IDLE unconditionally after 1 cycle.
REQ-018 SHALL keep the pipeline at 3 stages: S0 issues the read, S1 captures rd_r/rd_h, and S2 registers the result onto wr_*; steady-state latency from rd_en to wr_valid is 2 cycles.
REQ-019 SHALL sustain a throughput of 1 coefficient per cycle while wr_ready=1.
REQ-020 SHALL freeze S0-S2 while wr_valid && !wr_ready: rd_en=0, no address advance, wr_* stable.
REQ-021 SHALL iterate addresses coeff 0..255 within each poly, then poly 0..NPOLY-1; the coeff counter wraps 255->0 and increments poly.
REQ-022 SHALL compute (r1, r0) per coefficient via Decompose with package q and gamma2, and m=(q-1)/(2*gamma2).
REQ-023 SHALL output r1 when h=0.
REQ-024 SHALL output (r1+1) mod m when h=1 and signed r0>0, i.e. r1=m-1 gives 0.
REQ-025 SHALL output (r1-1) mod m when h=1 and r0<=0, i.e. r1=0 gives m-1; no negative remainders.
REQ-026 SHALL produce exactly NPOLY*256 write transfers per job, each address exactly once, in order.
REQ-027 SHALL ignore start outside IDLE, including in DONE.
REQ-028 SHALL allow start in the cycle after done to begin a new job with no gap.

Reset
REQ-029 SHALL, while reset=0, immediately force state=IDLE, counters=0, busy=0, done=0, rd_en=0, wr_valid=0, rd_addr=0, wr_addr=0, wr_data=0.
REQ-030 SHALL abort any job in flight on reset, with no further writes and no done pulse.

Structure
REQ-031 SHALL take q, gamma2 and k from Dilithium_pkg, and SHALL add m and the FSM state enum to it.
REQ-032 SHALL instantiate one sub-module, usehint_coeff, as a combinational Decompose plus hint adjust between S1 and S2.

Verification
REQ-033 SHALL verify r=0, h=1 (gamma2=(q-1)/32, m=16) -> wr_data=15.
REQ-034 SHALL verify r=1, h=1 -> 1; r=1, h=0 -> 0.
REQ-035 SHALL verify r=q-1 (r1=0, r0=-1), h=1 -> 15; h=0 -> 0.
REQ-036 SHALL verify a full job with wr_ready=1 -> 4*256 writes at addresses 0..1023 in order, first wr_valid 3 cycles after start, done 1 cycle after last transfer.
REQ-037 SHALL verify wr_ready low 5 cycles mid-job -> wr_addr/wr_data held, rd_en=0, no missing or duplicate addresses.
REQ-038 SHALL verify reset=0 at coefficient 300 -> all outputs 0 next edge, no done; a new start then produces a complete job from address 0.

Source files
------------

// File: rtl/Dilithium_pkg.sv
// Shared Dilithium constants plus the UseHint controller's derived modulus and FSM states.
package Dilithium_pkg;

    localparam int unsigned Q      = 8380417;
    localparam int unsigned GAMMA2 = (Q - 1) / 32;
    localparam int unsigned K      = 4;

    // Decompose step size and the number of distinct high parts.
    localparam int unsigned ALPHA  = 2 * GAMMA2;
    localparam int unsigned M      = (Q - 1) / ALPHA;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/usehint_ctrl_if.sv
// Job control, coefficient-read and result-write signals of the UseHint controller.
interface usehint_ctrl_if
    import Dilithium_pkg::*;
#(
    parameter int unsigned R_WIDTH  = 32,
    parameter int unsigned R1_WIDTH = 4,
    parameter int unsigned NPOLY    = K
);
    localparam int unsigned AW = $clog2(NPOLY) + 8;

    logic                start;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [R_WIDTH-1:0]  rd_r;
    logic                rd_h;
    logic                wr_valid;
    logic                wr_ready;
    logic [AW-1:0]       wr_addr;
    logic [R1_WIDTH-1:0] wr_data;

    // Controller side.
    modport master (
        input  start, rd_r, rd_h, wr_ready,
        output busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data
    );

    // Requester / memory / sink side.
    modport slave (
        output start, rd_r, rd_h, wr_ready,
        input  busy, done, rd_en, rd_addr, wr_valid, wr_addr, wr_data
    );

endinterface

// File: rtl/usehint_coeff.sv
// Combinational Decompose of one coefficient followed by the hint adjustment of its high part.
// The input is expected to be already reduced into [0, Q-1].
module usehint_coeff
    import Dilithium_pkg::*;
#(
    parameter int unsigned R_WIDTH  = 32,
    parameter int unsigned R1_WIDTH = 4
) (
    input  logic [R_WIDTH-1:0]  i_r,
    input  logic                i_h,
    output logic [R1_WIDTH-1:0] o_r1
);

    logic [63:0]        w_r;
    logic [63:0]        w_quot;
    logic [63:0]        w_r1;
    logic [63:0]        w_res;
    logic signed [63:0] w_r0;

    // Rounded quotient by threshold counting, centred remainder, wrap of the top bucket, hint.
    always_comb begin
        w_r    = 64'(i_r);
        w_quot = '0;
        // r belongs to bucket j when r > j*ALPHA - GAMMA2, giving r0 in (-GAMMA2, GAMMA2].
        for (int unsigned j = 1; j <= M; j++) begin
            if (w_r > 64'(j * ALPHA - GAMMA2)) begin
                w_quot = w_quot + 64'd1;
            end
        end
        w_r0 = $signed(w_r) - $signed(w_quot * 64'(ALPHA));
        w_r1 = w_quot;
        // r - r0 = Q-1 folds onto high part 0 with the low part pulled down by one.
        if (w_quot == 64'(M)) begin
            w_r1 = '0;
            w_r0 = w_r0 - 64'sd1;
        end
        if (!i_h) begin
            w_res = w_r1;
        end else if (w_r0 > 64'sd0) begin
            w_res = (w_r1 == 64'(M - 1)) ? '0 : w_r1 + 64'd1;
        end else begin
            w_res = (w_r1 == 64'd0) ? 64'(M - 1) : w_r1 - 64'd1;
        end
        o_r1 = R1_WIDTH'(w_res);
    end

endmodule

// File: rtl/usehint_ctrl.sv
// UseHint job controller: streams NPOLY*256 (r, h) pairs from memory through a
// 3-stage pipeline (issue, capture, register) and writes r1 results with back-pressure.
module usehint_ctrl
    import Dilithium_pkg::*;
#(
    parameter int unsigned R_WIDTH  = 32,
    parameter int unsigned R1_WIDTH = 4,
    parameter int unsigned NPOLY    = K
) (
    input logic            clk,
    input logic            reset,
    usehint_ctrl_if.master bus
);

    localparam int unsigned   AW        = $clog2(NPOLY) + 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPOLY * 256 - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [AW-1:0]       r_cnt;
    logic [AW-1:0]       w_cnt_next;
    logic                w_rd_en;
    logic                w_stall;

    logic                r_s1_valid;
    logic [AW-1:0]       r_s1_addr;
    logic                r_wr_valid;
    logic [AW-1:0]       r_wr_addr;
    logic [R1_WIDTH-1:0] r_wr_data;
    logic [R1_WIDTH-1:0] w_r1;

    // A pending write that the sink refuses freezes every stage.
    assign w_stall = r_wr_valid && !bus.wr_ready;

    // FSM state and read-address counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, counter advance and read strobe.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rd_en      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StRun;
                    w_cnt_next   = '0;
                end
            end
            StRun: begin
                if (!w_stall) begin
                    w_rd_en = 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_next = StDrain;
                        w_cnt_next   = '0;
                    end else begin
                        // {poly, coeff} as one counter: coeff 255 -> 0 carries into poly.
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (r_wr_valid && bus.wr_ready && (r_wr_addr == LAST_ADDR)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    usehint_coeff #(
        .R_WIDTH  (R_WIDTH),
        .R1_WIDTH (R1_WIDTH)
    ) u_coeff (
        .i_r  (bus.rd_r),
        .i_h  (bus.rd_h),
        .o_r1 (w_r1)
    );

    // S1 tags the memory output; S2 registers the result. Memory holds its data while frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_rd_en;
            r_s1_addr  <= r_cnt;
            r_wr_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_r1;
            end
        end
    end

    assign bus.busy     = (r_state == StRun) || (r_state == StDrain);
    assign bus.done     = (r_state == StDone);
    assign bus.rd_en    = w_rd_en;
    assign bus.rd_addr  = r_cnt;
    assign bus.wr_valid = r_wr_valid;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;

endmodule

// File: tb/tb_usehint_ctrl.sv
// Randomized bench for usehint_ctrl with a behavioural memory, sink and reference model.
module tb_usehint_ctrl;
    import Dilithium_pkg::*;

    localparam int unsigned NP = K;
    localparam int          N  = NP * 256;

    logic clk;
    logic reset;

    usehint_ctrl_if #(.R_WIDTH(32), .R1_WIDTH(4), .NPOLY(NP)) bus ();

    usehint_ctrl #(
        .R_WIDTH  (32),
        .R1_WIDTH (4),
        .NPOLY    (NP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem_r [N];
    logic        mem_h [N];
    bit          lit_on;
    int          ready_mode = 0;

    // model state
    int     cyc = 0;
    bit     m_idle = 1'b1;
    bit     m_active = 1'b0;
    int     acc_cyc = 0;
    int     exp_done_cyc = -1;
    int     exp_idx = 0;
    int     exp_rd = 0;
    bit     first_seen = 1'b0;
    int     done_cnt = 0;
    bit     prev_stall = 1'b0;
    longint prev_addr = 0;
    longint prev_data = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decompose + UseHint straight from the arithmetic definition.
    function automatic longint usehint_ref(input longint r, input bit h);
        longint lq, la, lg, lm, rp, r0, r1;
        lq = longint'(Q);
        la = longint'(ALPHA);
        lg = longint'(GAMMA2);
        lm = longint'(M);
        rp = r % lq;
        r0 = rp % la;
        if (r0 > lg) r0 = r0 - la;
        if (rp - r0 == lq - 1) begin
            r1 = 0;
            r0 = r0 - 1;
        end else begin
            r1 = (rp - r0) / la;
        end
        if (!h) return r1;
        if (r0 > 0) return (r1 + 1) % lm;
        return (r1 + lm - 1) % lm;
    endfunction

    function automatic longint lit_expect(input int a);
        case (a)
            0: return 15;
            1: return 1;
            2: return 0;
            3: return 15;
            default: return 0;
        endcase
    endfunction

    task automatic fill_mem(input bit with_lit);
        int unsigned sel, kk;
        for (int i = 0; i < N; i++) begin
            sel = $urandom_range(0, 3);
            kk  = $urandom_range(0, 15);
            case (sel)
                0: mem_r[i] = $urandom_range(0, Q - 1);
                1: mem_r[i] = kk * ALPHA + GAMMA2 + $urandom_range(0, 2) - 1;
                2: mem_r[i] = Q - 1 - $urandom_range(0, 3);
                default: mem_r[i] = kk * ALPHA + $urandom_range(0, 2);
            endcase
            mem_h[i] = 1'($urandom_range(0, 1));
        end
        lit_on = with_lit;
        if (with_lit) begin
            mem_r[0] = 0;     mem_h[0] = 1'b1;
            mem_r[1] = 1;     mem_h[1] = 1'b1;
            mem_r[2] = 1;     mem_h[2] = 1'b0;
            mem_r[3] = Q - 1; mem_h[3] = 1'b1;
            mem_r[4] = Q - 1; mem_h[4] = 1'b0;
        end
    endtask

    // Memory: data for a read strobed in cycle t appears in cycle t+1 and is held otherwise.
    initial begin
        bit          pend;
        logic [9:0]  pa;
        bus.rd_r = '0;
        bus.rd_h = 1'b0;
        forever begin
            @(negedge clk);
            pend = bus.rd_en;
            pa   = bus.rd_addr;
            @(posedge clk);
            #1;
            if (pend) begin
                bus.rd_r = mem_r[pa];
                bus.rd_h = mem_h[pa];
            end
        end
    end

    // Sink ready: 0 always ready, 1 random 75 %, 2 held low.
    initial begin
        bus.wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.wr_ready = 1'b1;
                1:       bus.wr_ready = ($urandom_range(0, 3) != 0);
                default: bus.wr_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        bit exp_busy, exp_done, cur_stall;
        cyc++;
        if (!reset) begin
            check("reset_outputs", {bus.busy, bus.done, bus.rd_en, bus.wr_valid,
                                    bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
            m_idle       = 1'b1;
            m_active     = 1'b0;
            exp_done_cyc = -1;
            prev_stall   = 1'b0;
        end else begin
            exp_busy = m_active && (cyc > acc_cyc) && (exp_done_cyc < 0 || cyc < exp_done_cyc);
            exp_done = m_active && (cyc == exp_done_cyc);
            check("busy", bus.busy, exp_busy);
            check("done", bus.done, exp_done);
            if (bus.done) begin
                done_cnt++;
                check("xfers_at_done", exp_idx, N);
            end
            if (bus.rd_en) begin
                check("rd_in_job", (m_active && cyc > acc_cyc && exp_rd < N), 1);
                check("rd_addr", bus.rd_addr, exp_rd);
                exp_rd++;
            end
            cur_stall = bus.wr_valid && !bus.wr_ready;
            if (cur_stall) check("rd_en_in_stall", bus.rd_en, 0);
            if (prev_stall) begin
                check("held_valid", bus.wr_valid, 1);
                check("held_addr", bus.wr_addr, prev_addr);
                check("held_data", bus.wr_data, prev_data);
            end
            if (bus.wr_valid) begin
                check("wr_valid_in_job", m_active, 1);
                if (m_active && !first_seen) begin
                    check("first_valid_latency", cyc - acc_cyc, 3);
                    first_seen = 1'b1;
                end
            end
            if (bus.wr_valid && bus.wr_ready && m_active && exp_idx < N) begin
                check("wr_addr", bus.wr_addr, exp_idx);
                check("wr_data", bus.wr_data, usehint_ref(mem_r[exp_idx], mem_h[exp_idx]));
                if (lit_on && exp_idx < 5) begin
                    check("wr_data_literal", bus.wr_data, lit_expect(exp_idx));
                end
                exp_idx++;
                if (exp_idx == N) exp_done_cyc = cyc + 1;
            end else if (bus.wr_valid && bus.wr_ready) begin
                check("extra_write", bus.wr_addr, -1);
            end
            prev_stall = cur_stall;
            prev_addr  = bus.wr_addr;
            prev_data  = bus.wr_data;
            // Start is honoured only in idle; done returns to idle next cycle.
            if (m_idle && bus.start) begin
                m_idle       = 1'b0;
                m_active     = 1'b1;
                acc_cyc      = cyc;
                exp_idx      = 0;
                exp_rd       = 0;
                first_seen   = 1'b0;
                exp_done_cyc = -1;
            end
            if (exp_done) begin
                m_active = 1'b0;
                m_idle   = 1'b1;
            end
        end
    end

    task automatic wait_until_idx(input int target);
        int t = 0;
        while (exp_idx < target && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_idx < target) check("timeout_idx", exp_idx, target);
    endtask

    task automatic wait_done();
        int t  = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        fill_mem(1'b1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;

        check("pin_r0_h1", usehint_ref(0, 1'b1), 15);
        check("pin_r1_h1", usehint_ref(1, 1'b1), 1);
        check("pin_r1_h0", usehint_ref(1, 1'b0), 0);
        check("pin_qm1_h1", usehint_ref(Q - 1, 1'b1), 15);
        check("pin_qm1_h0", usehint_ref(Q - 1, 1'b0), 0);
        check("pin_m", M, 16);

        // Job A: sink always ready.
        pulse_start();
        wait_done();

        // Job B: starts the cycle after done, random back-pressure, 5-cycle hold mid-job.
        fill_mem(1'b0);
        ready_mode = 1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_until_idx(400);
        ready_mode = 2;
        repeat (5) @(negedge clk);
        ready_mode = 1;
        pulse_start();
        wait_until_idx(N);
        // Start raised only during the done cycle must be ignored.
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);

        // Job C: reset once coefficient 300 has been written.
        fill_mem(1'b0);
        pulse_start();
        wait_until_idx(301);
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {bus.busy, bus.done, bus.rd_en, bus.wr_valid,
                                      bus.rd_addr, bus.wr_addr, bus.wr_data}, 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (10) @(negedge clk);

        // Job D: complete job from address 0 after the abort.
        fill_mem(1'b0);
        pulse_start();
        wait_done();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
